// File: rtl/vend_dispenser.sv
// rtl/vend_dispenser.sv - product motor and coin hopper sequencer with stock tracking
module vend_dispenser #(
  parameter int MOTOR_CYCLES = 8,
  parameter int COIN_PULSE   = 4,
  parameter int COIN_GAP     = 2,
  parameter int STOCK_W      = 8,
  parameter int PRODUCT_INIT = 10,
  parameter int COIN5_INIT   = 10,
  parameter int COIN10_INIT  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vend_in,
  input  logic [1:0]         change_in,
  input  logic               refill,
  input  logic [STOCK_W-1:0] refill_product,
  input  logic [STOCK_W-1:0] refill_c5,
  input  logic [STOCK_W-1:0] refill_c10,
  output logic               motor_on,
  output logic               eject5,
  output logic               eject10,
  output logic               busy,
  output logic               done,
  output logic               short_change,
  output logic               overrun,
  output logic [STOCK_W-1:0] product_cnt,
  output logic [STOCK_W-1:0] coin5_cnt,
  output logic [STOCK_W-1:0] coin10_cnt
);

  localparam int TW = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MOTOR    = 3'd1,
    COIN_ON  = 3'd2,
    COIN_OFF = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        owed_q, owed_d;
  logic              sel10_q, sel10_d;
  logic [STOCK_W-1:0] prod_d, c5_d, c10_d;
  logic              short_d, overrun_d;

  logic              req;
  logic [2:0]        chg_units;
  logic              sel_go;
  logic [2:0]        sel_owed;

  // Decode a request and the change owed in Rs5 units; 11 counts as no change.
  always_comb begin
    req = vend_in | (change_in == 2'b01) | (change_in == 2'b10);
    case (change_in)
      2'b01:   chg_units = 3'd1;
      2'b10:   chg_units = 3'd2;
      default: chg_units = 3'd0;
    endcase
  end

  // Next-state logic: sequencing, coin selection, stock updates and flags.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    owed_d    = owed_q;
    sel10_d   = sel10_q;
    prod_d    = product_cnt;
    c5_d      = coin5_cnt;
    c10_d     = coin10_cnt;
    short_d   = short_change;
    overrun_d = overrun;
    sel_go    = 1'b0;
    sel_owed  = 3'd0;

    case (state_q)
      IDLE: begin
        // Refill lands first so a same-cycle request sees the new stock.
        if (refill) begin
          prod_d  = refill_product;
          c5_d    = refill_c5;
          c10_d   = refill_c10;
          short_d = 1'b0;
        end
        if (req) begin
          if (vend_in && (prod_d != '0)) begin
            prod_d  = prod_d - 1'b1;
            owed_d  = chg_units;
            timer_d = '0;
            state_d = MOTOR;
          end else begin
            // Sold out: refund the Rs15 price on top of any change.
            sel_go   = 1'b1;
            sel_owed = chg_units + (vend_in ? 3'd3 : 3'd0);
          end
        end
      end
      MOTOR: begin
        if (timer_q == TW'(MOTOR_CYCLES - 1)) begin
          sel_go   = 1'b1;
          sel_owed = owed_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      COIN_ON: begin
        if (timer_q == TW'(COIN_PULSE - 1)) begin
          timer_d = '0;
          state_d = COIN_OFF;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      COIN_OFF: begin
        if (timer_q == TW'(COIN_GAP - 1)) begin
          sel_go   = 1'b1;
          sel_owed = owed_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Coin selection: prefer Rs10 while two or more units are owed.
    if (sel_go) begin
      timer_d = '0;
      if (sel_owed == 3'd0) begin
        owed_d  = 3'd0;
        state_d = DONE;
      end else if ((sel_owed >= 3'd2) && (c10_d != '0)) begin
        sel10_d = 1'b1;
        c10_d   = c10_d - 1'b1;
        owed_d  = sel_owed - 3'd2;
        state_d = COIN_ON;
      end else if (c5_d != '0) begin
        sel10_d = 1'b0;
        c5_d    = c5_d - 1'b1;
        owed_d  = sel_owed - 3'd1;
        state_d = COIN_ON;
      end else begin
        short_d = 1'b1;
        owed_d  = 3'd0;
        state_d = DONE;
      end
    end

    if ((state_q != IDLE) && req) begin
      overrun_d = 1'b1;
    end
  end

  // State, stock and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      owed_q       <= 3'd0;
      sel10_q      <= 1'b0;
      product_cnt  <= STOCK_W'(PRODUCT_INIT);
      coin5_cnt    <= STOCK_W'(COIN5_INIT);
      coin10_cnt   <= STOCK_W'(COIN10_INIT);
      short_change <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      owed_q       <= owed_d;
      sel10_q      <= sel10_d;
      product_cnt  <= prod_d;
      coin5_cnt    <= c5_d;
      coin10_cnt   <= c10_d;
      short_change <= short_d;
      overrun      <= overrun_d;
    end
  end

  // Drive lines decode directly from the registered state, so they are exclusive.
  always_comb begin
    motor_on = (state_q == MOTOR);
    eject5   = (state_q == COIN_ON) && !sel10_q;
    eject10  = (state_q == COIN_ON) && sel10_q;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
  end

endmodule
